// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch-predictor update path.
// Optional statistics counters are enabled by BPRED_UPD_STATS_EN.
package bpred_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  localparam logic [1:0] BPRED_CNT_WEAK_NT = 2'b01;

  localparam int unsigned BPRED_ADDR_W = 32;
  localparam int unsigned BPRED_TGT_W  = 32;

  // addr is sized for the largest table; narrower tables zero-extend
  typedef struct packed {
    logic [BPRED_TGT_W-1:0]  target;
    logic                    mispred;
    logic                    taken;
    logic [BPRED_ADDR_W-1:0] addr;
  } bpred_fb_t;

  function automatic logic [31:0] bpred_sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bpred_fb_fifo.sv
// Synchronous FIFO for resolved-branch feedback.
// Clear has priority over push and pop in the same cycle.
module bpred_fb_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o && !clr_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Update-port sequencer: table init walk, feedback FIFO drain, predict enable.
// Define BPRED_UPD_STATS_EN to build the train/mispredict counters.
module bpred_update_ctrl
  import bpred_pkg::*;
#(
  parameter  int unsigned NUM_ENTRIES = 1024,
  parameter  int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned IDXW        = $clog2(NUM_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fb_valid_i,
  input  logic [IDXW-1:0] fb_addr_i,
  input  logic            fb_taken_i,
  input  logic            fb_mispred_i,
  input  logic [31:0]     fb_target_i,
  input  logic            flush_req_i,
  output logic            fifo_full_o,
  output logic            overflow_o,
  output logic            predict_en_o,
  output logic            upd_valid_o,
  output logic            upd_init_o,
  output logic [IDXW-1:0] upd_addr_o,
  output logic            upd_taken_o,
  output logic            upd_btb_we_o,
  output logic [31:0]     upd_target_o,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int unsigned FBW = $bits(bpred_fb_t);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_ENTRIES - 1);

  bpred_state_e state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;

  bpred_fb_t fb_ent;
  bpred_fb_t fifo_head;
  logic [FBW-1:0] fifo_rdata;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic [CW-1:0] unused_cnt;
  logic [BPRED_ADDR_W-1:0] unused_head_addr;

  logic            upd_valid_q, upd_valid_d;
  logic            upd_init_q, upd_init_d;
  logic [IDXW-1:0] upd_addr_q, upd_addr_d;
  logic            upd_taken_q, upd_taken_d;
  logic            upd_btb_we_q, upd_btb_we_d;
  logic [31:0]     upd_target_q, upd_target_d;
  logic            predict_en_q, predict_en_d;
  logic            overflow_q, overflow_d;

  assign fb_ent = '{
    target:  fb_target_i,
    mispred: fb_mispred_i,
    taken:   fb_taken_i,
    addr:    BPRED_ADDR_W'(fb_addr_i)
  };

  assign fifo_head        = fifo_rdata;
  assign unused_head_addr = fifo_head.addr;

  bpred_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FBW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (flush_req_i),
    .push_i  (fifo_push),
    .wdata_i (fb_ent),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_cnt)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    overflow_d   = overflow_q;
    predict_en_d = (state_q == ST_RUN);
    upd_valid_d  = 1'b0;
    upd_init_d   = 1'b0;
    upd_addr_d   = '0;
    upd_taken_d  = 1'b0;
    upd_btb_we_d = 1'b0;
    upd_target_d = '0;
    unique case (state_q)
      ST_INIT: begin
        upd_valid_d = 1'b1;
        upd_init_d  = 1'b1;
        upd_addr_d  = idx_q;
        idx_d       = idx_q + IDXW'(1);
        if (idx_q == IDX_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          upd_valid_d  = 1'b1;
          upd_addr_d   = fifo_head.addr[IDXW-1:0];
          upd_taken_d  = fifo_head.taken;
          upd_btb_we_d = fifo_head.mispred;
          upd_target_d = fifo_head.target;
        end
        if (fb_valid_i) begin
          if (fifo_full) overflow_d = 1'b1;
          else           fifo_push  = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // the update chosen this cycle still goes out; the restart lands next edge
    if (flush_req_i) begin
      state_d = ST_INIT;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_init_q   <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      upd_btb_we_q <= 1'b0;
      upd_target_q <= '0;
      predict_en_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      upd_valid_q  <= upd_valid_d;
      upd_init_q   <= upd_init_d;
      upd_addr_q   <= upd_addr_d;
      upd_taken_q  <= upd_taken_d;
      upd_btb_we_q <= upd_btb_we_d;
      upd_target_q <= upd_target_d;
      predict_en_q <= predict_en_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_full_o  = (state_q == ST_RUN) && fifo_full;
  assign overflow_o   = overflow_q;
  assign predict_en_o = predict_en_q;
  assign upd_valid_o  = upd_valid_q;
  assign upd_init_o   = upd_init_q;
  assign upd_addr_o   = upd_addr_q;
  assign upd_taken_o  = upd_taken_q;
  assign upd_btb_we_o = upd_btb_we_q;
  assign upd_target_o = upd_target_q;

`ifdef BPRED_UPD_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (flush_req_i) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (fifo_pop) begin
      stat_br_q <= bpred_sat_inc(stat_br_q);
      if (fifo_head.mispred) stat_mis_q <= bpred_sat_inc(stat_mis_q);
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mis_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule
